// File: rtl/vga_pkg.sv
// Shared definitions for the 160x120, 3-bit-colour display path:
// screen defaults, coordinate widths, colour type, plotter FSM states
// and the rectangle clipping helper.
package vga_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef logic [2:0] colour_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Visible extent of a span starting at origin with the requested
    // length, on an axis of size limit. 9 bits so origin+extent cannot wrap.
    function automatic logic [8:0] clip_extent(input logic [8:0] origin,
                                               input logic [8:0] extent,
                                               input logic [8:0] limit);
        logic [8:0] room;
        if (origin >= limit) begin
            return 9'd0;
        end
        room = limit - origin;
        return (extent > room) ? room : extent;
    endfunction

endpackage

// File: rtl/rect_plotter_raster_counter.sv
// raster_counter: loadable x/y scan counter. Holds the current pixel,
// steps in raster order (x inner, y outer) on enable and flags the last
// pixel of the loaded rectangle. Comes out of reset already loaded with
// the full-screen rectangle at (0,0) so the power-up clear needs no load.
module raster_counter
    import vga_pkg::*;
#(
    parameter int RESET_W = SCREEN_W_DEF,
    parameter int RESET_H = SCREEN_H_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [X_W-1:0] origin_x,
    input  logic [Y_W-1:0] origin_y,
    input  logic [X_W-1:0] extent_w,
    input  logic [Y_W-1:0] extent_h,
    input  logic           load,
    input  logic           enable,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic [X_W-1:0] x_reg;
    logic [Y_W-1:0] y_reg;
    logic [X_W-1:0] x0_reg;
    logic [X_W-1:0] x_end_reg;
    logic [Y_W-1:0] y_end_reg;

    // Load a new rectangle (extents are already clipped and non-zero) or step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            x0_reg    <= '0;
            x_end_reg <= X_W'(RESET_W - 1);
            y_end_reg <= Y_W'(RESET_H - 1);
        end else if (load) begin
            x_reg     <= origin_x;
            y_reg     <= origin_y;
            x0_reg    <= origin_x;
            x_end_reg <= origin_x + extent_w - X_W'(1);
            y_end_reg <= origin_y + extent_h - Y_W'(1);
        end else if (enable) begin
            if (x_reg == x_end_reg) begin
                x_reg <= x0_reg;
                y_reg <= y_reg + Y_W'(1);
            end else begin
                x_reg <= x_reg + X_W'(1);
            end
        end
    end

    assign x    = x_reg;
    assign y    = y_reg;
    assign last = (x_reg == x_end_reg) && (y_reg == y_end_reg);

endmodule

// File: rtl/rect_plotter.sv
// rect_plotter: filled-rectangle pixel-write engine feeding vga_adapter.
// One pixel per clock, clipping at capture, power-up clear and init_done.
// Optional macro RECT_PLOTTER_FRAME_CLEAR_EN: when defined, CLEAR paints
// the whole screen with CLEAR_COLOUR; otherwise CLEAR lasts one cycle.
// The counter registers drive x/y directly, so the first pixel of an
// accepted request appears on the accept edge itself.
module rect_plotter
    import vga_pkg::*;
#(
    parameter int      SCREEN_W     = SCREEN_W_DEF,
    parameter int      SCREEN_H     = SCREEN_H_DEF,
    parameter colour_t CLEAR_COLOUR = 3'b000
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           req,
    input  logic [X_W-1:0] req_x,
    input  logic [Y_W-1:0] req_y,
    input  logic [X_W-1:0] req_w,
    input  logic [Y_W-1:0] req_h,
    input  colour_t        req_colour,
    output logic           ready,
    output logic           done,
    output logic           init_done,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output colour_t        colour,
    output logic           plot
);

    state_t     state_reg, state_next;
    logic       ready_reg, ready_next;
    logic       done_reg, done_next;
    logic       init_done_reg, init_done_next;
    logic       plot_reg, plot_next;
    colour_t    colour_reg, colour_next;

    logic [8:0] w_eff, h_eff;
    logic       area_zero;
    logic       accept;
    logic       cnt_load, cnt_enable, cnt_last;

    assign w_eff     = clip_extent({1'b0, req_x}, {1'b0, req_w}, 9'(SCREEN_W));
    assign h_eff     = clip_extent({2'b0, req_y}, {2'b0, req_h}, 9'(SCREEN_H));
    assign area_zero = (w_eff == 9'd0) || (h_eff == 9'd0);
    // ready is high exactly while in IDLE, so the state alone gates capture.
    assign accept    = (state_reg == ST_IDLE) && req;

    assign cnt_load  = accept && !area_zero;
`ifdef RECT_PLOTTER_FRAME_CLEAR_EN
    // First CLEAR cycle shows (0,0) without stepping; afterwards step each clock.
    assign cnt_enable = ((state_reg == ST_DRAW) || (state_reg == ST_CLEAR && plot_reg)) && !cnt_last;
`else
    assign cnt_enable = (state_reg == ST_DRAW) && !cnt_last;
`endif

    raster_counter #(
        .RESET_W (SCREEN_W),
        .RESET_H (SCREEN_H)
    ) u_scan (
        .clock    (clock),
        .reset_n  (reset_n),
        .origin_x (req_x),
        .origin_y (req_y),
        .extent_w (w_eff[X_W-1:0]),
        .extent_h (h_eff[Y_W-1:0]),
        .load     (cnt_load),
        .enable   (cnt_enable),
        .x        (x),
        .y        (y),
        .last     (cnt_last)
    );

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_CLEAR;
            ready_reg     <= 1'b0;
            done_reg      <= 1'b0;
            init_done_reg <= 1'b0;
            plot_reg      <= 1'b0;
            colour_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            ready_reg     <= ready_next;
            done_reg      <= done_next;
            init_done_reg <= init_done_next;
            plot_reg      <= plot_next;
            colour_reg    <= colour_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: begin
`ifdef RECT_PLOTTER_FRAME_CLEAR_EN
                if (plot_reg && cnt_last) state_next = ST_IDLE;
`else
                state_next = ST_IDLE;
`endif
            end
            ST_IDLE:  if (accept) state_next = area_zero ? ST_DONE : ST_DRAW;
            ST_DRAW:  if (cnt_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // Outputs are a registered function of the state being entered.
    always_comb begin
        ready_next     = (state_next == ST_IDLE);
        done_next      = (state_next == ST_DONE);
        init_done_next = (state_next != ST_CLEAR);
`ifdef RECT_PLOTTER_FRAME_CLEAR_EN
        plot_next      = (state_next == ST_DRAW) || (state_next == ST_CLEAR);
`else
        plot_next      = (state_next == ST_DRAW);
`endif
        colour_next    = colour_reg;
        if (state_reg == ST_CLEAR) begin
            colour_next = CLEAR_COLOUR;
        end else if (cnt_load) begin
            colour_next = req_colour;
        end
    end

    assign ready     = ready_reg;
    assign done      = done_reg;
    assign init_done = init_done_reg;
    assign plot      = plot_reg;
    assign colour    = colour_reg;

endmodule

// File: doc/rect_plotter.md
# rect_plotter

Pixel-write engine that sits directly upstream of the `vga_adapter` in the 160x120, 3-bit-colour display path. It accepts filled-rectangle draw requests from game logic (enemy, hands, player sprites) and emits one `x`/`y`/`colour`/`plot` pixel write per clock. It also owns power-up screen clearing and the `init_done` signal that gates the rest of the game.

## Interface
- `SCREEN_W`, default 160: horizontal resolution in pixels.
- `SCREEN_H`, default 120: vertical resolution in pixels.
- `CLEAR_COLOUR`, default 3'b000: colour used by the power-up clear.

Ports:
- `clock`  in  1  system clock (CLOCK_50 domain).
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `req`  in  1  draw request, sampled only while `ready`=1.
- `req_x`  in  8  top-left x.
- `req_y`  in  7  top-left y.
- `req_w`  in  8  width in pixels.
- `req_h`  in  7  height in pixels.
- `req_colour`  in  3  fill colour.
- `ready`  out  1  engine idle and `init_done`=1.
- `done`  out  1  one-cycle pulse when a request finishes.
- `init_done`  out  1  power-up sequence complete; stays high until reset.
- `x`  out  8  pixel x to the adapter.
- `y`  out  7  pixel y to the adapter.
- `colour`  out  3  pixel colour to the adapter.
- `plot`  out  1  pixel write strobe.

## Operation
- FSM states: CLEAR, IDLE, DRAW, DONE.
- Reset (async assert) forces CLEAR. All outputs are 0 during reset: `x`, `y`, `colour`, `plot`, `done`, `ready`, `init_done`.
- Reset mid-draw discards the in-flight request. No pending state survives.
- IDLE: `ready`=1. If `req`=1 on a clock edge, the engine captures all `req_*` fields and goes to DRAW. If `req`=1 while `ready`=0, the request is ignored and not queued.
- Clipping is applied at capture, using 9-bit arithmetic:
  - `w_eff` = 0 if `req_x` >= SCREEN_W, else min(`req_w`, SCREEN_W-`req_x`).
  - `h_eff` is defined the same way from `req_y`, `req_h` and SCREEN_H.
- If `w_eff`=0 or `h_eff`=0, the engine goes straight to DONE and produces no plot.
- DRAW: raster order, x inner loop, y outer loop. The engine emits one pixel per clock with `plot`=1 and `colour`=captured colour.
  - x wraps from `req_x`+`w_eff`-1 back to `req_x` and y increments.
  - After the pixel (`req_x`+`w_eff`-1, `req_y`+`h_eff`-1) the engine goes to DONE.
- DONE: `done`=1 for exactly one cycle, `plot`=0, then IDLE.
- `plot`=0 in IDLE and DONE. `x`, `y` and `colour` hold their last values while `plot`=0.

## Timing
- All outputs are registered.
- Request accepted at edge N:
  - first `plot` at cycle N+1;
  - last `plot` at cycle N+`w_eff`*`h_eff`;
  - `done` at cycle N+`w_eff`*`h_eff`+1;
  - `ready` back high the following cycle.
- Zero-area request: `done` at cycle N+1 and no plot.
- Throughput: one pixel per clock. There are 2 overhead cycles per request (done cycle and return to IDLE).

## Configuration
- Macro `RECT_PLOTTER_FRAME_CLEAR_EN`.
- Defined:
  - CLEAR scans every pixel (0,0)..(SCREEN_W-1,SCREEN_H-1) in raster order with CLEAR_COLOUR and `plot`=1.
  - With the default parameters this is 19200 writes, in cycles 1..19200 after reset release.
  - `init_done` and `ready` rise at cycle 19201.
- Undefined:
  - CLEAR lasts one cycle with no plot.
  - `init_done` and `ready` rise at cycle 1 after reset release.

## Structure
- Shared package `vga_pkg` holds:
  - SCREEN_W and SCREEN_H defaults;
  - coordinate widths (8-bit x, 7-bit y);
  - 3-bit colour typedef;
  - the FSM state enum.
- One sub-module, `raster_counter`: loadable x/y scan counter.
  - Inputs: origin, extent, load, enable.
  - Outputs: x, y, last.
  - Shared by CLEAR (origin 0, full-screen extent) and DRAW (captured origin, clipped extent).

## Test plan
- Reset release with the macro defined -> exactly 19200 plots with colour 000 covering every coordinate once, then `init_done`=`ready`=1 at cycle 19201.
- Request x=10, y=20, w=3, h=2, colour=3'b100 -> plots at (10,20), (11,20), (12,20), (10,21), (11,21), (12,21) in cycles N+1..N+6, `done` at N+7.
- Clipped request x=158, y=119, w=5, h=4 -> plots only at (158,119) and (159,119), `done` at N+3.
- Zero-area requests w=0, and separately x=200 -> no plot, `done` at N+1.
- `req` pulsed during DRAW is ignored. `reset_n` low mid-draw -> `plot`, `ready` and `init_done` drop immediately, and the clear restarts on release.
- `req` held high continuously -> back-to-back accepts separated by exactly the done cycle plus the IDLE cycle, with no pixels lost or duplicated.
